// File: rtl/eth_pkg.sv
// eth_pkg: shared state encoding, CRC-32 constants and frame header offsets
package eth_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_PRIME, S_TX, S_FCS, S_IFG} state_t;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int OFS_MAC_DST   = 8;
  localparam int OFS_MAC_SRC   = 14;
  localparam int OFS_ETHERTYPE = 20;
  localparam int OFS_IP        = 22;
  localparam int OFS_UDP       = 42;
  localparam int OFS_PAYLOAD   = 50;
endpackage

// File: rtl/eth_frame_sequencer_crc32_d8.sv
// crc32_d8: one-byte step of the reflected Ethernet CRC-32
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) crc_out = crc_out[0] ? (crc_out >> 1) ^ CRC32_POLY : crc_out >> 1;
  end
endmodule

// File: rtl/eth_frame_sequencer.sv
// eth_frame_sequencer: fills frame RAM payload, streams frame + FCS, enforces IFG
module eth_frame_sequencer
  import eth_pkg::*;
#(
  parameter int FRAME_LEN   = 1396,
  parameter int PAYLOAD_OFS = 50,
  parameter int PAYLOAD_LEN = 1346,
  parameter int CRC_START   = 8,
  parameter int IFG_BYTES   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  px_data,
  input  logic        px_valid,
  output logic        px_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_wr_en,
  input  logic [7:0]  ram_dout,
  output logic        busy,
  output logic [15:0] frame_cnt
);
  localparam logic [10:0] TX_LAST    = 11'(FRAME_LEN - 1);
  localparam logic [10:0] FILL_FIRST = 11'(PAYLOAD_OFS);
  localparam logic [10:0] FILL_LAST  = 11'(PAYLOAD_OFS + PAYLOAD_LEN - 1);
  localparam logic [10:0] CRC_FIRST  = 11'(CRC_START);
  localparam logic [7:0]  IFG_LAST   = 8'(IFG_BYTES - 1);
  state_t      state_q, state_d;
  logic [10:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]  k_q, k_d;
  logic [7:0]  ifg_q, ifg_d;
  logic [31:0] crc_q, crc_d, crc_nxt;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        px_ready_q, tx_valid_q, tx_last_q, busy_q, hs, wr;

  crc32_d8 u_crc (.crc_in(crc_q), .data(ram_dout), .crc_out(crc_nxt));

  always_comb begin
    hs          = tx_valid_q & tx_ready;
    wr          = (state_q == S_FILL) & px_valid & px_ready_q;
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    k_d         = k_q;
    ifg_d       = ifg_q;
    crc_d       = crc_q;
    frame_cnt_d = frame_cnt_q;
    ram_addr    = 11'd0;
    ram_din     = 8'd0;
    ram_wr_en   = 1'b0;
    tx_data     = 8'd0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_FILL;
        wr_ptr_d = FILL_FIRST;
        crc_d    = CRC32_INIT;
      end
      S_FILL: begin
        ram_addr  = wr_ptr_q;
        ram_din   = px_data;
        ram_wr_en = wr;
        if (wr) wr_ptr_d = wr_ptr_q + 11'd1;
        if (wr && wr_ptr_q == FILL_LAST) begin
          state_d  = S_PRIME;
          rd_ptr_d = 11'd0;
        end
      end
      S_PRIME: state_d = S_TX;
      S_TX: begin
        // address runs one ahead on acceptance so the registered RAM keeps pace
        tx_data  = ram_dout;
        ram_addr = rd_ptr_q + {10'd0, hs};
        rd_ptr_d = ram_addr;
        if (hs && rd_ptr_q >= CRC_FIRST) crc_d = crc_nxt;
        if (hs && rd_ptr_q == TX_LAST) begin
          state_d = S_FCS;
          k_d     = 2'd0;
        end
      end
      S_FCS: begin
        tx_data = ~crc_q[8*k_q +: 8];
        if (hs) k_d = k_q + 2'd1;
        if (hs && k_q == 2'd3) begin
          state_d     = S_IFG;
          ifg_d       = 8'd0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      S_IFG: begin
        ifg_d   = ifg_q + 8'd1;
        state_d = ifg_q == IFG_LAST ? S_IDLE : S_IFG;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= 11'd0;
      rd_ptr_q    <= 11'd0;
      k_q         <= 2'd0;
      ifg_q       <= 8'd0;
      crc_q       <= CRC32_INIT;
      frame_cnt_q <= 16'd0;
      px_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      k_q         <= k_d;
      ifg_q       <= ifg_d;
      crc_q       <= crc_d;
      frame_cnt_q <= frame_cnt_d;
      px_ready_q  <= state_d == S_FILL;
      tx_valid_q  <= state_d == S_TX || state_d == S_FCS;
      tx_last_q   <= state_d == S_FCS && k_d == 2'd3;
      busy_q      <= state_d != S_IDLE;
    end
  end

  assign px_ready  = px_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_last   = tx_last_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_eth_frame_sequencer.sv
// tb_eth_frame_sequencer: directed frame-level bench with a behavioural frame RAM
module tb_eth_frame_sequencer;
  import eth_pkg::*;
  localparam int PO = 50, PL = 1346, FL = 1396, NB = 1400;
  logic clk = 0, rst = 1, start = 0, px_valid = 0, tx_ready = 1;
  logic [7:0] px_data = 0, ram_dout = 0, tx_data, ram_din;
  logic px_ready, tx_valid, tx_last, ram_wr_en, busy;
  logic [10:0] ram_addr;
  logic [15:0] frame_cnt;
  logic [31:0] ut_c = 0, ut_o;
  logic [7:0] ut_d = 0;
  logic [7:0] mem [0:2047];
  logic [7:0] exp_f [0:NB-1];
  logic [7:0] rxb [0:2047];
  int compared = 0, failed = 0;
  int beats = 0, nlast = 0, lastpos = -1, stall_err = 0, wr_err = 0, drop_err = 0;
  bit tx_rand = 0;

  eth_frame_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .px_data(px_data), .px_valid(px_valid),
    .px_ready(px_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .ram_addr(ram_addr), .ram_din(ram_din), .ram_wr_en(ram_wr_en),
    .ram_dout(ram_dout), .busy(busy), .frame_cnt(frame_cnt)
  );
  crc32_d8 u_ref (.crc_in(ut_c), .data(ut_d), .crc_out(ut_o));

  always #5 clk = ~clk;

  function automatic logic [7:0] hdr(input int i);
    return i < 7 ? 8'h55 : i == 7 ? 8'hD5 : 8'(i * 7 + 3);
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = i < PO ? hdr(i) : 8'hEE;
    forever begin
      @(posedge clk);
      ram_dout <= mem[ram_addr];
      if (ram_wr_en) mem[ram_addr] = ram_din;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = tx_rand ? ($urandom_range(1) != 0) : 1'b1;
  end

  logic pv = 0, pr = 0;
  logic [7:0] pd = 0;
  bit in_frame = 0;
  always @(negedge clk) begin
    if (start && !busy && !rst) begin
      beats = 0;
      nlast = 0;
      lastpos = -1;
    end
    if (!rst && pv && !pr && tx_valid && tx_data !== pd) stall_err++;
    if (ram_wr_en && (!px_ready || !px_valid || ram_addr < 11'd50 || ram_addr >= 11'd1396)) wr_err++;
    if (!rst && in_frame && !tx_valid) drop_err++;
    if (rst) in_frame = 0;
    else if (tx_valid && tx_ready) begin
      if (beats < 2048) rxb[beats] = tx_data;
      if (tx_last) begin
        nlast++;
        lastpos = beats;
      end
      in_frame = !tx_last;
      beats++;
    end
    pv = tx_valid;
    pr = tx_ready;
    pd = tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic feed(input int pct);
    int j = 0, c = 0;
    bit acc;
    while (j < PL && c < 20000) begin
      px_data = 8'(j);
      px_valid = $urandom_range(99) < 32'(pct);
      acc = px_valid && px_ready;
      tick();
      c++;
      if (acc) j++;
    end
    px_valid = 0;
    if (j < PL) begin
      compared++;
      failed++;
      $display("FAIL feed: %0d payload bytes accepted, required %0d", j, PL);
    end
  endtask

  task automatic wait_done(input string nm);
    int c = 0;
    while (!(nlast != 0 && !busy) && c < 40000) begin
      tick();
      c++;
    end
    if (c >= 40000) begin
      compared++;
      failed++;
      $display("FAIL %s_timeout: beats=%0d, required %0d and idle", nm, beats, NB);
    end
  endtask

  task automatic stats(output int bad, output logic [31:0] res);
    bad = 0;
    res = 32'hFFFFFFFF;
    for (int i = 0; i < beats && i < 2048; i++) begin
      if (i >= NB || rxb[i] !== exp_f[i]) bad++;
      if (i >= 8) res = crc_upd(res, rxb[i]);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    compared++;
    if ({px_ready, tx_valid, tx_last, ram_wr_en, busy} !== 5'b0) begin
      failed++;
      $display("FAIL reset_flags: got %b, required 00000", {px_ready, tx_valid, tx_last, ram_wr_en, busy});
    end
    compared++;
    if (ram_addr !== 11'd0) begin failed++; $display("FAIL reset_addr: got %0d, required 0", ram_addr); end
    compared++;
    if (ram_din !== 8'd0) begin failed++; $display("FAIL reset_din: got %h, required 00", ram_din); end
    compared++;
    if (frame_cnt !== 16'd0) begin failed++; $display("FAIL reset_cnt: got %0d, required 0", frame_cnt); end
    rst = 0;
    tick();
  endtask

  task automatic test_crc_unit();
    ut_c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      ut_d = 8'h31 + 8'(i);
      #1;
      ut_c = ut_o;
    end
    compared++;
    if (~ut_c !== 32'hCBF43926) begin failed++; $display("FAIL crc_check: got %h, required cbf43926", ~ut_c); end
  endtask

  task automatic test_full_frame();
    int bad;
    logic [31:0] res;
    pulse_start();
    feed(100);
    wait_done("full");
    stats(bad, res);
    compared++;
    if (beats !== NB) begin failed++; $display("FAIL full_beats: got %0d, required %0d", beats, NB); end
    compared++;
    if (bad !== 0) begin failed++; $display("FAIL full_bytes: %0d bytes wrong, required 0", bad); end
    compared++;
    if (nlast !== 1 || lastpos !== NB - 1) begin
      failed++;
      $display("FAIL full_last: %0d last flags at beat %0d, required 1 at %0d", nlast, lastpos, NB - 1);
    end
    compared++;
    if (res !== CRC32_RESIDUE) begin failed++; $display("FAIL full_residue: got %h, required debb20e3", res); end
    compared++;
    if (frame_cnt !== 16'd1) begin failed++; $display("FAIL full_cnt: got %0d, required 1", frame_cnt); end
  endtask

  task automatic test_random();
    int bad;
    logic [31:0] res;
    tx_rand = 1;
    pulse_start();
    feed(30);
    wait_done("random");
    tx_rand = 0;
    stats(bad, res);
    compared++;
    if (beats !== NB || bad !== 0) begin
      failed++;
      $display("FAIL random_stream: %0d beats with %0d wrong bytes, required %0d and 0", beats, bad, NB);
    end
    compared++;
    if (res !== CRC32_RESIDUE) begin failed++; $display("FAIL random_residue: got %h, required debb20e3", res); end
    compared++;
    if (stall_err !== 0) begin failed++; $display("FAIL random_stall: %0d unstable stalls, required 0", stall_err); end
    compared++;
    if (wr_err !== 0) begin failed++; $display("FAIL random_write: %0d illegal writes, required 0", wr_err); end
    compared++;
    if (drop_err !== 0) begin failed++; $display("FAIL random_valid: %0d tx_valid drops, required 0", drop_err); end
    compared++;
    if (frame_cnt !== 16'd2) begin failed++; $display("FAIL random_cnt: got %0d, required 2", frame_cnt); end
  endtask

  task automatic test_start_ignored();
    int bad, c = 0;
    logic [31:0] res;
    pulse_start();
    tick();
    tick();
    pulse_start();
    feed(100);
    repeat (5) tick();
    pulse_start();
    while (nlast == 0 && c < 5000) begin
      tick();
      c++;
    end
    tick();
    tick();
    pulse_start();
    wait_done("ignore");
    repeat (20) tick();
    stats(bad, res);
    compared++;
    if (busy !== 1'b0 || px_ready !== 1'b0) begin
      failed++;
      $display("FAIL ignore_idle: busy=%b px_ready=%b, required 0 0", busy, px_ready);
    end
    compared++;
    if (beats !== NB || bad !== 0) begin
      failed++;
      $display("FAIL ignore_stream: %0d beats with %0d wrong bytes, required %0d and 0", beats, bad, NB);
    end
    compared++;
    if (frame_cnt !== 16'd3) begin failed++; $display("FAIL ignore_cnt: got %0d, required 3", frame_cnt); end
  endtask

  task automatic test_ifg();
    int bad, c = 0, pxr_hi = 0;
    logic b11 = 0, b12 = 1;
    logic [31:0] res;
    pulse_start();
    feed(100);
    while (!(tx_last && tx_valid && tx_ready) && c < 5000) begin
      tick();
      c++;
    end
    tick();
    for (int i = 1; i <= 13; i++) begin
      start = (i == 5 || i == 13);
      tick();
      if (i <= 12 && px_ready) pxr_hi++;
      if (i == 11) b11 = busy;
      if (i == 12) b12 = busy;
    end
    start = 0;
    compared++;
    if (pxr_hi !== 0) begin failed++; $display("FAIL ifg_pxready: high %0d cycles in gap, required 0", pxr_hi); end
    compared++;
    if (b11 !== 1'b1 || b12 !== 1'b0) begin
      failed++;
      $display("FAIL ifg_length: busy after 11/12 cycles %b/%b, required 1/0", b11, b12);
    end
    compared++;
    if (px_ready !== 1'b1) begin failed++; $display("FAIL ifg_restart: px_ready=%b, required 1", px_ready); end
    feed(100);
    wait_done("ifg");
    stats(bad, res);
    compared++;
    if (beats !== NB || bad !== 0) begin
      failed++;
      $display("FAIL ifg_stream: %0d beats with %0d wrong bytes, required %0d and 0", beats, bad, NB);
    end
    compared++;
    if (frame_cnt !== 16'd5) begin failed++; $display("FAIL ifg_cnt: got %0d, required 5", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    int bad, c = 0;
    logic [31:0] res;
    pulse_start();
    feed(100);
    while (beats < 700 && c < 5000) begin
      tick();
      c++;
    end
    rst = 1;
    tick();
    compared++;
    if ({px_ready, tx_valid, tx_last, ram_wr_en, busy} !== 5'b0 || ram_addr !== 11'd0 || ram_din !== 8'd0) begin
      failed++;
      $display("FAIL midrst_outputs: flags=%b addr=%0d din=%h, required 00000 0 00",
               {px_ready, tx_valid, tx_last, ram_wr_en, busy}, ram_addr, ram_din);
    end
    compared++;
    if (frame_cnt !== 16'd0) begin failed++; $display("FAIL midrst_cnt: got %0d, required 0", frame_cnt); end
    rst = 0;
    tick();
    pulse_start();
    feed(100);
    wait_done("midrst");
    stats(bad, res);
    compared++;
    if (beats !== NB || bad !== 0) begin
      failed++;
      $display("FAIL midrst_stream: %0d beats with %0d wrong bytes, required %0d and 0", beats, bad, NB);
    end
    compared++;
    if (res !== CRC32_RESIDUE) begin failed++; $display("FAIL midrst_residue: got %h, required debb20e3", res); end
    compared++;
    if (frame_cnt !== 16'd1 || wr_err !== 0) begin
      failed++;
      $display("FAIL midrst_after: cnt=%0d illegal_writes=%0d, required 1 and 0", frame_cnt, wr_err);
    end
  endtask

  initial begin
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < FL; i++) exp_f[i] = i < PO ? hdr(i) : 8'(i - PO);
    for (int i = 8; i < FL; i++) c = crc_upd(c, exp_f[i]);
    c = ~c;
    for (int b = 0; b < 4; b++) exp_f[FL + b] = c[8*b +: 8];
    test_reset();
    test_crc_unit();
    test_full_frame();
    test_random();
    test_start_ignored();
    test_ifg();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
